// File: rtl/laser_enable_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : laser_enable_sequencer
// Purpose  : Laser power-up / arming / fault-shutdown sequencer with latched
//            fault causes. Define LASER_WDOG_EN to include the host watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module laser_enable_sequencer #(
  parameter int PGOOD_DEBOUNCE = 1000,
  parameter int PGOOD_TIMEOUT  = 250000,
  parameter int ENABLE_SETTLE  = 25000,
  parameter int WDOG_TIMEOUT   = 25000000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       enable_req,
  input  logic       laser_ready,
  input  logic       pwr_good,
  input  logic       wdog_kick,
  input  logic       clear_fail,
  input  logic [3:0] fault_in,
  output logic       laser_pwr_en,
  output logic       ta_shutdown,
  output logic       watchdog_timeout,
  output logic [5:0] fault_latched,
  output logic [2:0] seq_state
);

  localparam int c_DEB_W = (PGOOD_DEBOUNCE > 1) ? $clog2(PGOOD_DEBOUNCE) : 1;
  localparam int c_TMO_W = (PGOOD_TIMEOUT > 1) ? $clog2(PGOOD_TIMEOUT) : 1;
  localparam int c_SET_W = (ENABLE_SETTLE > 1) ? $clog2(ENABLE_SETTLE) : 1;

  localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(PGOOD_DEBOUNCE - 1);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(PGOOD_TIMEOUT - 1);
  localparam logic [c_SET_W-1:0] c_SET_LAST = c_SET_W'(ENABLE_SETTLE - 1);
  localparam logic [c_DEB_W-1:0] c_DEB_ONE  = c_DEB_W'(1);
  localparam logic [c_TMO_W-1:0] c_TMO_ONE  = c_TMO_W'(1);
  localparam logic [c_SET_W-1:0] c_SET_ONE  = c_SET_W'(1);

  typedef enum logic [2:0] {
    ST_OFF        = 3'd0,
    ST_WAIT_PGOOD = 3'd1,
    ST_SETTLE     = 3'd2,
    ST_ARMED      = 3'd3,
    ST_FAULT      = 3'd4
  } state_t;

  state_t               r_state;
  logic                 r_pwr_en;
  logic                 r_ta_shutdown;
  logic [5:0]           r_fault_latched;
  logic [c_DEB_W-1:0]   r_deb_cnt;
  logic [c_TMO_W-1:0]   r_tmo_cnt;
  logic [c_SET_W-1:0]   r_set_cnt;

  state_t               w_next_state;
  logic [5:0]           w_fault_set;
  logic                 w_clear;
  logic [c_DEB_W-1:0]   w_deb_nxt;
  logic [c_TMO_W-1:0]   w_tmo_nxt;
  logic [c_SET_W-1:0]   w_set_nxt;
  logic                 w_deb_hit;
  logic                 w_tmo_hit;
  logic                 w_set_hit;
  logic                 w_wdg_hit;

  // Counters are held at zero outside their own state, so hits need no state qualifier.
  assign w_deb_hit = pwr_good && (r_deb_cnt == c_DEB_LAST);
  assign w_tmo_hit = (r_tmo_cnt == c_TMO_LAST);
  assign w_set_hit = (r_set_cnt == c_SET_LAST);

`ifdef LASER_WDOG_EN
  localparam int c_WDG_W = (WDOG_TIMEOUT > 1) ? $clog2(WDOG_TIMEOUT) : 1;
  localparam logic [c_WDG_W-1:0] c_WDG_LAST = c_WDG_W'(WDOG_TIMEOUT - 1);
  localparam logic [c_WDG_W-1:0] c_WDG_ONE  = c_WDG_W'(1);

  logic [c_WDG_W-1:0] r_wdg_cnt;
  logic [c_WDG_W-1:0] w_wdg_nxt;
  logic               r_wdog_timeout;

  // A kick on the terminal-count cycle restarts the count instead of faulting.
  assign w_wdg_hit = (r_state == ST_ARMED) && !wdog_kick && (r_wdg_cnt == c_WDG_LAST);
  assign w_wdg_nxt = (r_state != ST_ARMED || wdog_kick) ? '0 :
                     (r_wdg_cnt == c_WDG_LAST) ? r_wdg_cnt : r_wdg_cnt + c_WDG_ONE;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wdg_cnt      <= '0;
      r_wdog_timeout <= 1'b0;
    end else begin
      r_wdg_cnt      <= (w_next_state != r_state) ? '0 : w_wdg_nxt;
      r_wdog_timeout <= w_clear ? 1'b0 : (r_wdog_timeout | w_fault_set[5]);
    end
  end

  assign watchdog_timeout = r_wdog_timeout;
`else
  logic w_unused_kick;
  assign w_unused_kick    = wdog_kick;
  assign w_wdg_hit        = 1'b0;
  assign watchdog_timeout = 1'b0;
`endif

  always_comb begin
    w_next_state = r_state;
    w_fault_set  = '0;
    w_clear      = 1'b0;
    w_deb_nxt    = '0;
    w_tmo_nxt    = '0;
    w_set_nxt    = '0;
    case (r_state)
      ST_OFF: begin
        if (enable_req && laser_ready && (r_fault_latched == '0))
          w_next_state = ST_WAIT_PGOOD;
      end
      ST_WAIT_PGOOD: begin
        w_tmo_nxt = w_tmo_hit ? r_tmo_cnt : r_tmo_cnt + c_TMO_ONE;
        if (pwr_good)
          w_deb_nxt = (r_deb_cnt == c_DEB_LAST) ? r_deb_cnt : r_deb_cnt + c_DEB_ONE;
        if (!laser_ready) begin
          w_next_state = ST_OFF;
        end else if ((fault_in != '0) || w_tmo_hit) begin
          w_next_state = ST_FAULT;
          w_fault_set  = {1'b0, w_tmo_hit, fault_in};
        end else if (!enable_req) begin
          w_next_state = ST_OFF;
        end else if (w_deb_hit) begin
          w_next_state = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        w_set_nxt = w_set_hit ? r_set_cnt : r_set_cnt + c_SET_ONE;
        if (!laser_ready) begin
          w_next_state = ST_OFF;
        end else if ((fault_in != '0) || !pwr_good) begin
          w_next_state = ST_FAULT;
          w_fault_set  = {1'b0, !pwr_good, fault_in};
        end else if (!enable_req) begin
          w_next_state = ST_OFF;
        end else if (w_set_hit) begin
          w_next_state = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (!laser_ready) begin
          w_next_state = ST_OFF;
        end else if ((fault_in != '0) || !pwr_good || w_wdg_hit) begin
          w_next_state = ST_FAULT;
          w_fault_set  = {w_wdg_hit, !pwr_good, fault_in};
        end else if (!enable_req) begin
          w_next_state = ST_OFF;
        end
      end
      ST_FAULT: begin
        // FAULT holds through laser_ready loss so latched causes stay clearable.
        w_fault_set = {2'b00, fault_in};
        if (clear_fail && !enable_req && (fault_in == '0)) begin
          w_next_state = ST_OFF;
          w_clear      = 1'b1;
        end
      end
      default: w_next_state = ST_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state         <= ST_OFF;
      r_pwr_en        <= 1'b0;
      r_ta_shutdown   <= 1'b1;
      r_fault_latched <= '0;
      r_deb_cnt       <= '0;
      r_tmo_cnt       <= '0;
      r_set_cnt       <= '0;
    end else begin
      r_state         <= w_next_state;
      r_pwr_en        <= (w_next_state == ST_WAIT_PGOOD) || (w_next_state == ST_SETTLE) ||
                         (w_next_state == ST_ARMED);
      r_ta_shutdown   <= (w_next_state != ST_ARMED);
      r_fault_latched <= w_clear ? '0 : (r_fault_latched | w_fault_set);
      r_deb_cnt       <= (w_next_state != r_state) ? '0 : w_deb_nxt;
      r_tmo_cnt       <= (w_next_state != r_state) ? '0 : w_tmo_nxt;
      r_set_cnt       <= (w_next_state != r_state) ? '0 : w_set_nxt;
    end
  end

  assign laser_pwr_en  = r_pwr_en;
  assign ta_shutdown   = r_ta_shutdown;
  assign fault_latched = r_fault_latched;
  assign seq_state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_laser_enable_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_laser_enable_sequencer
// Purpose  : Directed vector bench for laser_enable_sequencer (small counts).
// Revision : 1.0 - initial release
// ============================================================================
module tb_laser_enable_sequencer;

`ifdef LASER_WDOG_EN
  localparam bit c_WDOG = 1'b1;
`else
  localparam bit c_WDOG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic       enable_req;
  logic       laser_ready;
  logic       pwr_good;
  logic       wdog_kick;
  logic       clear_fail;
  logic [3:0] fault_in;
  logic       laser_pwr_en;
  logic       ta_shutdown;
  logic       watchdog_timeout;
  logic [5:0] fault_latched;
  logic [2:0] seq_state;

  laser_enable_sequencer #(
    .PGOOD_DEBOUNCE(4),
    .PGOOD_TIMEOUT (20),
    .ENABLE_SETTLE (8),
    .WDOG_TIMEOUT  (16)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .enable_req      (enable_req),
    .laser_ready     (laser_ready),
    .pwr_good        (pwr_good),
    .wdog_kick       (wdog_kick),
    .clear_fail      (clear_fail),
    .fault_in        (fault_in),
    .laser_pwr_en    (laser_pwr_en),
    .ta_shutdown     (ta_shutdown),
    .watchdog_timeout(watchdog_timeout),
    .fault_latched   (fault_latched),
    .seq_state       (seq_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       rdy;
    logic       pg;
    logic       clr;
    logic [3:0] flt;
    int         n;
    logic [2:0] st;
    logic       pe;
    logic       sd;
    logic [5:0] lat;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic add(input logic en, input logic rdy, input logic pg, input logic clr,
                     input logic [3:0] flt, input int n, input logic [2:0] st,
                     input logic pe, input logic sd, input logic [5:0] lat);
    vec_t v;
    v.en = en; v.rdy = rdy; v.pg = pg; v.clr = clr; v.flt = flt; v.n = n;
    v.st = st; v.pe = pe; v.sd = sd; v.lat = lat;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] st, input logic pe,
                           input logic sd, input logic [5:0] lat, input logic wd);
    check({tag, " seq_state"}, {5'b0, seq_state}, {5'b0, st});
    check({tag, " laser_pwr_en"}, {7'b0, laser_pwr_en}, {7'b0, pe});
    check({tag, " ta_shutdown"}, {7'b0, ta_shutdown}, {7'b0, sd});
    check({tag, " fault_latched"}, {2'b0, fault_latched}, {2'b0, lat});
    check({tag, " watchdog_timeout"}, {7'b0, watchdog_timeout}, {7'b0, wd});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rstn = 1'b0; enable_req = 1'b0; laser_ready = 1'b0; pwr_good = 1'b0;
    wdog_kick = 1'b0; clear_fail = 1'b0; fault_in = 4'h0;

    //   en rdy pg clr flt   n  st pe sd lat
    add(0, 1, 1, 0, 4'h0, 2,  0, 0, 1, 6'h00);  // idle
    add(1, 1, 1, 0, 4'h0, 1,  1, 1, 1, 6'h00);  // power-up
    add(1, 1, 1, 0, 4'h0, 3,  1, 1, 1, 6'h00);
    add(1, 1, 1, 0, 4'h0, 1,  2, 1, 1, 6'h00);  // debounce done
    add(1, 1, 1, 0, 4'h0, 7,  2, 1, 1, 6'h00);
    add(1, 1, 1, 0, 4'h0, 1,  3, 1, 0, 6'h00);  // armed
    add(1, 1, 1, 0, 4'h4, 1,  4, 0, 1, 6'h04);  // limit fault pulse
    add(1, 1, 1, 1, 4'h0, 1,  4, 0, 1, 6'h04);  // clear with enable high ignored
    add(0, 1, 1, 0, 4'h0, 1,  4, 0, 1, 6'h04);
    add(0, 1, 1, 1, 4'h0, 1,  0, 0, 1, 6'h00);  // clear
    add(0, 1, 1, 0, 4'h0, 1,  0, 0, 1, 6'h00);
    add(1, 1, 0, 0, 4'h0, 1,  1, 1, 1, 6'h00);  // power timeout
    add(1, 1, 0, 0, 4'h0, 19, 1, 1, 1, 6'h00);
    add(1, 1, 0, 0, 4'h0, 1,  4, 0, 1, 6'h10);
    add(0, 1, 1, 1, 4'h8, 1,  4, 0, 1, 6'h18);  // fault beats clear
    add(0, 1, 1, 1, 4'h0, 1,  0, 0, 1, 6'h00);
    add(0, 1, 1, 0, 4'h0, 1,  0, 0, 1, 6'h00);
    add(1, 1, 1, 0, 4'h0, 1,  1, 1, 1, 6'h00);  // enable drop in WAIT
    add(0, 1, 1, 0, 4'h0, 1,  0, 0, 1, 6'h00);
    add(1, 1, 1, 0, 4'h0, 1,  1, 1, 1, 6'h00);  // debounce glitch
    add(1, 1, 1, 0, 4'h0, 2,  1, 1, 1, 6'h00);
    add(1, 1, 0, 0, 4'h0, 1,  1, 1, 1, 6'h00);
    add(1, 1, 1, 0, 4'h0, 3,  1, 1, 1, 6'h00);
    add(1, 1, 1, 0, 4'h0, 1,  2, 1, 1, 6'h00);
    add(1, 1, 1, 0, 4'h0, 3,  2, 1, 1, 6'h00);
    add(1, 1, 0, 0, 4'h0, 1,  4, 0, 1, 6'h10);  // pgood loss in SETTLE
    add(0, 1, 1, 1, 4'h0, 1,  0, 0, 1, 6'h00);
    add(0, 1, 1, 0, 4'h0, 1,  0, 0, 1, 6'h00);
    add(0, 1, 1, 0, 4'hF, 2,  0, 0, 1, 6'h00);  // faults ignored in OFF
    add(1, 1, 1, 0, 4'hF, 1,  1, 1, 1, 6'h00);
    add(1, 1, 1, 0, 4'hF, 1,  4, 0, 1, 6'h0F);
    add(0, 1, 1, 1, 4'hF, 1,  4, 0, 1, 6'h0F);  // clear blocked by live fault
    add(0, 1, 1, 1, 4'h0, 1,  0, 0, 1, 6'h00);
    add(0, 1, 1, 0, 4'h0, 1,  0, 0, 1, 6'h00);
    add(1, 1, 1, 0, 4'h0, 1,  1, 1, 1, 6'h00);  // laser_ready loss
    add(1, 0, 1, 0, 4'h0, 1,  0, 0, 1, 6'h00);
    add(1, 0, 1, 0, 4'h0, 2,  0, 0, 1, 6'h00);
    add(1, 1, 1, 0, 4'h0, 1,  1, 1, 1, 6'h00);  // debounce + timeout same cycle
    add(1, 1, 0, 0, 4'h0, 16, 1, 1, 1, 6'h00);
    add(1, 1, 1, 0, 4'h0, 3,  1, 1, 1, 6'h00);
    add(1, 1, 1, 0, 4'h0, 1,  4, 0, 1, 6'h10);
    add(0, 1, 1, 1, 4'h0, 1,  0, 0, 1, 6'h00);
    add(0, 1, 1, 0, 4'h0, 1,  0, 0, 1, 6'h00);
    add(1, 1, 1, 0, 4'h0, 1,  1, 1, 1, 6'h00);  // arm, then enable drop
    add(1, 1, 1, 0, 4'h0, 4,  2, 1, 1, 6'h00);
    add(1, 1, 1, 0, 4'h0, 8,  3, 1, 0, 6'h00);
    add(0, 1, 1, 0, 4'h0, 1,  0, 0, 1, 6'h00);
    add(1, 1, 1, 0, 4'h0, 1,  1, 1, 1, 6'h00);  // arm, then pgood loss
    add(1, 1, 1, 0, 4'h0, 4,  2, 1, 1, 6'h00);
    add(1, 1, 1, 0, 4'h0, 8,  3, 1, 0, 6'h00);
    add(1, 1, 0, 0, 4'h0, 1,  4, 0, 1, 6'h10);
    add(0, 1, 1, 1, 4'h0, 1,  0, 0, 1, 6'h00);
    add(1, 1, 1, 0, 4'h0, 1,  1, 1, 1, 6'h00);  // arm for watchdog
    add(1, 1, 1, 0, 4'h0, 4,  2, 1, 1, 6'h00);
    add(1, 1, 1, 0, 4'h0, 8,  3, 1, 0, 6'h00);

    #12;
    check_all("reset", 3'd0, 1'b0, 1'b1, 6'h00, 1'b0);
    #5 rstn = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      enable_req  = tbl[i].en;
      laser_ready = tbl[i].rdy;
      pwr_good    = tbl[i].pg;
      clear_fail  = tbl[i].clr;
      fault_in    = tbl[i].flt;
      step(tbl[i].n);
      check_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].pe, tbl[i].sd, tbl[i].lat, 1'b0);
    end

    // Regular kicks keep ARMED alive
    for (int k = 0; k < 10; k++) begin
      wdog_kick = 1'b0;
      step(9);
      wdog_kick = 1'b1;
      step(1);
      wdog_kick = 1'b0;
      check($sformatf("kick%0d seq_state", k), {5'b0, seq_state}, 8'd3);
    end
    step(15);
    check("pre_terminal seq_state", {5'b0, seq_state}, 8'd3);
    wdog_kick = 1'b1;  // kick lands on the terminal-count cycle
    step(1);
    wdog_kick = 1'b0;
    check_all("kick_on_terminal", 3'd3, 1'b1, 1'b0, 6'h00, 1'b0);
    step(15);
    check("wdog_almost seq_state", {5'b0, seq_state}, 8'd3);
    step(1);
    if (c_WDOG)
      check_all("wdog_expire", 3'd4, 1'b0, 1'b1, 6'h20, 1'b1);
    else
      check_all("wdog_absent", 3'd3, 1'b1, 1'b0, 6'h00, 1'b0);

    enable_req = 1'b0;
    clear_fail = 1'b1;
    step(1);
    clear_fail = 1'b0;
    check_all("back_off", 3'd0, 1'b0, 1'b1, 6'h00, 1'b0);

    // Asynchronous reset in the middle of SETTLE
    enable_req = 1'b1;
    step(1);
    step(4);
    step(2);
    check_all("settle_before_reset", 3'd2, 1'b1, 1'b1, 6'h00, 1'b0);
    #3 rstn = 1'b0;
    #1;
    check_all("async_reset", 3'd0, 1'b0, 1'b1, 6'h00, 1'b0);
    #13 rstn = 1'b1;
    step(2);
    check_all("after_reset", 3'd1, 1'b1, 1'b1, 6'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
